// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse letter encoder:
//   - state_t     : encoder FSM states (IDLE, SEND, GAP)
//   - PAT_W       : default width of the left-justified pattern register
//   - MAX_LEN     : longest code length in units (letter C)
//   - CODE_x/LEN_x: per-letter on/off unit pattern (right-aligned, MSB-first
//                   in time) and its length in units
//   - letter_code : letter index (0 = A .. 7 = H) -> {code, length}
// -----------------------------------------------------------------------------
package morse_pkg;

  localparam int unsigned PAT_W   = 12;
  localparam int unsigned MAX_LEN = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [MAX_LEN-1:0] code;
    logic [3:0]         len;
  } code_t;

  // Unit patterns: 1 = lamp on for one unit. Dot = 1, dash = 111,
  // symbols separated by a single 0.
  localparam logic [MAX_LEN-1:0] CODE_A = 11'b000_0001_0111;
  localparam logic [MAX_LEN-1:0] CODE_B = 11'b001_1101_0101;
  localparam logic [MAX_LEN-1:0] CODE_C = 11'b111_0101_1101;
  localparam logic [MAX_LEN-1:0] CODE_D = 11'b000_0111_0101;
  localparam logic [MAX_LEN-1:0] CODE_E = 11'b000_0000_0001;
  localparam logic [MAX_LEN-1:0] CODE_F = 11'b001_0101_1101;
  localparam logic [MAX_LEN-1:0] CODE_G = 11'b001_1101_1101;
  localparam logic [MAX_LEN-1:0] CODE_H = 11'b000_0101_0101;

  localparam logic [3:0] LEN_A = 4'd5;
  localparam logic [3:0] LEN_B = 4'd9;
  localparam logic [3:0] LEN_C = 4'd11;
  localparam logic [3:0] LEN_D = 4'd7;
  localparam logic [3:0] LEN_E = 4'd1;
  localparam logic [3:0] LEN_F = 4'd9;
  localparam logic [3:0] LEN_G = 4'd9;
  localparam logic [3:0] LEN_H = 4'd7;

  function automatic code_t letter_code(input logic [2:0] letter);
    code_t c;
    unique case (letter)
      3'd0:    c = '{code: CODE_A, len: LEN_A};
      3'd1:    c = '{code: CODE_B, len: LEN_B};
      3'd2:    c = '{code: CODE_C, len: LEN_C};
      3'd3:    c = '{code: CODE_D, len: LEN_D};
      3'd4:    c = '{code: CODE_E, len: LEN_E};
      3'd5:    c = '{code: CODE_F, len: LEN_F};
      3'd6:    c = '{code: CODE_G, len: LEN_G};
      default: c = '{code: CODE_H, len: LEN_H};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/morse_rom.sv
// -----------------------------------------------------------------------------
// morse_rom
// Combinational letter lookup. Produces the letter's unit pattern
// left-justified in a PAT_W-bit word (first unit in the MSB) and its length.
// Ports:
//   Letter  in  3        letter select, 0 = A .. 7 = H
//   Pattern out PAT_W    left-justified unit pattern, zero-filled below
//   Length  out 4        number of units in the pattern
// -----------------------------------------------------------------------------
module morse_rom
  import morse_pkg::*;
#(
  parameter int unsigned PAT_W = morse_pkg::PAT_W
) (
  input  logic [2:0]       Letter,
  output logic [PAT_W-1:0] Pattern,
  output logic [3:0]       Length
);

  code_t            entry;
  logic [PAT_W-1:0] wide;
  logic [3:0]       pad;

  // Codes are stored right-aligned in MAX_LEN bits. Placing them at the top
  // of the word and shifting left by the unused leading positions brings the
  // first unit of every letter into the MSB.
  always_comb begin
    entry                      = letter_code(Letter);
    wide                       = '0;
    wide[PAT_W-1 -: MAX_LEN]   = entry.code;
    pad                        = 4'(MAX_LEN) - entry.len;
    Pattern                    = wide << pad;
    Length                     = entry.len;
  end

endmodule

// File: rtl/morse_encoder.sv
// -----------------------------------------------------------------------------
// morse_encoder
// Plays one Morse letter (A-H) on a lamp, one unit per Tick pulse. The letter
// is latched on an accepted Start, shifted out MSB-first, followed by one
// silent unit and GAP_UNITS further off-units before a new Start is accepted.
// Ports:
//   ClockIn   in  1  system clock, rising edge
//   Reset     in  1  asynchronous, active-low reset
//   Tick      in  1  one-cycle unit pulse from the rate divider
//   Start     in  1  request; honoured only while idle
//   Letter    in  3  letter select (0 = A .. 7 = H), sampled on accepted Start
//   LightOut  out 1  registered lamp drive
//   Busy      out 1  high whenever the encoder is not idle
// -----------------------------------------------------------------------------
module morse_encoder
  import morse_pkg::*;
#(
  parameter int unsigned PAT_W     = morse_pkg::PAT_W,
  parameter int unsigned GAP_UNITS = 3
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic       Tick,
  input  logic       Start,
  input  logic [2:0] Letter,
  output logic       LightOut,
  output logic       Busy
);

  localparam logic [1:0] GAP_LOAD = 2'(GAP_UNITS - 1);

  state_t           state;
  logic [PAT_W-1:0] shift;
  logic [3:0]       count;
  logic [1:0]       gap_cnt;

  logic [PAT_W-1:0] rom_pattern;
  logic [3:0]       rom_length;

  morse_rom #(
    .PAT_W(PAT_W)
  ) u_rom (
    .Letter (Letter),
    .Pattern(rom_pattern),
    .Length (rom_length)
  );

  // A Tick coincident with an accepted Start is not consumed: the load uses
  // the cycle, and the first symbol waits for the next Tick, so every symbol
  // spans a full Tick period.
  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      shift    <= '0;
      count    <= '0;
      gap_cnt  <= '0;
      LightOut <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          LightOut <= 1'b0;
          if (Start) begin
            shift <= rom_pattern;
            count <= rom_length;
            state <= SEND;
          end
        end

        SEND: begin
          if (Tick) begin
            if (count != '0) begin
              LightOut <= shift[PAT_W-1];
              shift    <= {shift[PAT_W-2:0], 1'b0};
              count    <= count - 4'd1;
            end else begin
              // Pattern exhausted: this unit is the first silent one.
              LightOut <= 1'b0;
              gap_cnt  <= GAP_LOAD;
              state    <= GAP;
            end
          end
        end

        GAP: begin
          if (Tick) begin
            if (gap_cnt == '0) begin
              state <= IDLE;
            end else begin
              gap_cnt <= gap_cnt - 2'd1;
            end
          end
        end

        default: begin
          state    <= IDLE;
          LightOut <= 1'b0;
        end
      endcase
    end
  end

  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_morse_encoder.sv
// -----------------------------------------------------------------------------
// tb_morse_encoder
// Self-checking bench for morse_encoder. Tick is driven directly. Expected
// lamp sequences come either from a table of literal unit codes or from a
// dot/dash string model of the Morse alphabet.
// -----------------------------------------------------------------------------
module tb_morse_encoder;

  localparam int GAP = 3;

  logic       ClockIn = 1'b0;
  logic       Reset   = 1'b0;
  logic       Tick    = 1'b0;
  logic       Start   = 1'b0;
  logic [2:0] Letter  = 3'd0;
  logic       LightOut;
  logic       Busy;

  int errors = 0;
  int checks = 0;

  typedef bit bitq_t[$];

  typedef struct {
    logic [2:0]  letter;
    logic [10:0] code;
    int          len;
    int          lo;
    int          hi;
  } vec_t;

  morse_encoder #(
    .PAT_W    (12),
    .GAP_UNITS(GAP)
  ) dut (
    .ClockIn (ClockIn),
    .Reset   (Reset),
    .Tick    (Tick),
    .Start   (Start),
    .Letter  (Letter),
    .LightOut(LightOut),
    .Busy    (Busy)
  );

  always #5 ClockIn = ~ClockIn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: expand dots/dashes into units, then one silent unit for the
  // end of the letter and GAP off-units of inter-letter spacing.
  function automatic bitq_t model(input int l);
    string m [8];
    string s;
    bitq_t q;
    m = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};
    s = m[l];
    for (int i = 0; i < s.len(); i++) begin
      if (i > 0) q.push_back(1'b0);
      if (s[i] == "-") begin
        q.push_back(1'b1); q.push_back(1'b1); q.push_back(1'b1);
      end else begin
        q.push_back(1'b1);
      end
    end
    q.push_back(1'b0);
    for (int g = 0; g < GAP; g++) q.push_back(1'b0);
    return q;
  endfunction

  function automatic bitq_t from_code(input logic [10:0] code, input int len);
    bitq_t q;
    for (int i = len - 1; i >= 0; i--) q.push_back(code[i]);
    for (int g = 0; g < 1 + GAP; g++) q.push_back(1'b0);
    return q;
  endfunction

  task automatic pulse_tick();
    @(negedge ClockIn); Tick = 1'b1;
    @(negedge ClockIn); Tick = 1'b0;
  endtask

  task automatic start_letter(input logic [2:0] l, input bit with_tick);
    @(negedge ClockIn);
    Start = 1'b1; Letter = l; Tick = with_tick;
    @(negedge ClockIn);
    Start = 1'b0; Tick = 1'b0;
    Letter = 3'($urandom);
    chk("busy_after_start", 32'(Busy), 32'd1);
    chk("lamp_after_start", 32'(LightOut), 32'd0);
  endtask

  // Applies one Tick per expected unit with lo..hi idle cycles before each;
  // optionally pulses Start (Letter = B) together with tick number poke_at.
  task automatic play(input string tag, input bitq_t exp, input int lo, input int hi,
                      input int poke_at);
    int  sp;
    int  n;
    bit  prev;
    n    = exp.size();
    prev = 1'b0;
    for (int k = 1; k <= n; k++) begin
      sp = $urandom_range(hi, lo);
      repeat (sp) @(negedge ClockIn);
      if (sp > 0) begin
        chk({tag, "_hold_lamp"}, 32'(LightOut), 32'(prev));
      end
      @(negedge ClockIn);
      Tick = 1'b1;
      if (k == poke_at) begin
        Start = 1'b1; Letter = 3'd1;
      end
      @(negedge ClockIn);
      Tick = 1'b0; Start = 1'b0;
      chk({tag, "_lamp"}, 32'(LightOut), 32'(exp[k-1]));
      chk({tag, "_busy"}, 32'(Busy), 32'(k < n));
      prev = exp[k-1];
    end
    repeat (2) pulse_tick();
    chk({tag, "_idle_busy"}, 32'(Busy), 32'd0);
    chk({tag, "_idle_lamp"}, 32'(LightOut), 32'd0);
  endtask

  initial begin
    vec_t  tbl [8];
    bitq_t q;
    int    l;

    tbl = '{
      '{3'd0, 11'b10111,       5,  2, 2},
      '{3'd4, 11'b1,           1,  0, 3},
      '{3'd2, 11'b11101011101, 11, 1, 4},
      '{3'd1, 11'b111010101,   9,  0, 0},
      '{3'd3, 11'b1110101,     7,  3, 3},
      '{3'd5, 11'b101011101,   9,  0, 2},
      '{3'd6, 11'b111011101,   9,  1, 1},
      '{3'd7, 11'b1010101,     7,  0, 4}
    };

    // Reset held with Start and Tick active: nothing may start.
    Start = 1'b1; Letter = 3'd2;
    for (int i = 0; i < 8; i++) begin
      @(negedge ClockIn); Tick = ~Tick;
      chk("rst_lamp", 32'(LightOut), 32'd0);
      chk("rst_busy", 32'(Busy), 32'd0);
    end
    Start = 1'b0; Tick = 1'b0;
    @(negedge ClockIn); Reset = 1'b1;
    repeat (3) @(negedge ClockIn);
    chk("post_rst_busy", 32'(Busy), 32'd0);
    chk("post_rst_lamp", 32'(LightOut), 32'd0);

    // Table of literal codes, each with its own Tick spacing.
    foreach (tbl[i]) begin
      start_letter(tbl[i].letter, 1'b0);
      play($sformatf("tbl%0d", tbl[i].letter), from_code(tbl[i].code, tbl[i].len),
           tbl[i].lo, tbl[i].hi, 0);
    end

    // Start for B during H is ignored; H completes and no B follows.
    start_letter(3'd7, 1'b0);
    play("ignore_h", model(7), 1, 2, 3);

    // Start and Tick coincident in IDLE: Tick not consumed.
    start_letter(3'd0, 1'b1);
    repeat (3) begin
      @(negedge ClockIn);
      chk("coinc_lamp", 32'(LightOut), 32'd0);
    end
    play("coinc_a", model(0), 1, 3, 0);

    // Reset in the middle of G's first dash drops lamp and Busy immediately.
    start_letter(3'd6, 1'b0);
    pulse_tick();
    pulse_tick();
    chk("g_dash_lamp", 32'(LightOut), 32'd1);
    #2 Reset = 1'b0;
    #1;
    chk("async_rst_lamp", 32'(LightOut), 32'd0);
    chk("async_rst_busy", 32'(Busy), 32'd0);
    @(negedge ClockIn); Reset = 1'b1;
    start_letter(3'd3, 1'b0);
    play("after_rst_d", from_code(11'b1110101, 7), 0, 2, 0);

    // Random letters, random Tick spacing, random coincident Tick on Start.
    for (int r = 0; r < 20; r++) begin
      l = $urandom_range(7, 0);
      start_letter(3'(l), 1'($urandom_range(1, 0)));
      q = model(l);
      play($sformatf("rnd%0d", r), q, 0, 4, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
